avr_core: RTL and testbench

- Minimal AVR-subset 8-bit CPU executing 16-bit opcodes from a synchronous 16K-word program ROM.
- Accesses an external data memory with a 22-bit word address.
- Multi-cycle, non-pipelined. It sits between the program ROM and the RAM/SDRAM controller model.

---
 rtl/avr_core.sv | 260 ++++++++++++++++++++++++++
 tb/tb_avr_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/avr_core.sv
// avr_core: minimal multi-cycle AVR-subset 8-bit CPU.
// Sequence per instruction: FETCH -> WAIT -> EXEC (-> MEM for LD/ST) -> FETCH.
// The program ROM is synchronous, so its word is valid from WAIT onward.
// Optional feature: define AVR_MUL_EN to implement MUL Rd,Rr into {R1,R0}.
// Without AVR_MUL_EN, the MUL opcode executes as a NOP.
module avr_core #(
  parameter logic [13:0] RESET_PC = 14'h0000
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [13:0] ROM_A,
  input  logic [15:0] ROM_I,
  output logic [21:0] ADR_O,
  input  logic [15:0] DAT_I,
  output logic [15:0] DAT_O,
  output logic        WE_O
);

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, MEM} state_t;

  state_t      state, state_nxt;
  logic [13:0] pc;
  logic [7:0]  rf [32];
  logic [7:0]  sreg;
  logic        mem_ld_q;
  logic [4:0]  mem_rd_q;

  // Operand fields of the word currently presented by the ROM
  logic [15:0] op;
  logic [4:0]  d5, r5, dh;
  logic [7:0]  kimm, rd_v, rr_v, rdh_v;
  logic signed [13:0] br_off, rj_off;
  logic        use_c;
  logic [8:0]  add9, sub9, subi9;
  logic [15:0] prod;

  // Decode results consumed in EXEC
  logic [13:0] pc_nxt;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  sreg_nxt;
  logic        mul_en;
  logic        go_mem;
  logic        mem_ld;

  // FSM-derived strobes
  logic        exec_en;
  logic        mem_en;

  // Upper data byte is not part of the datapath
  logic        unused_dat_hi;
  assign unused_dat_hi = ^DAT_I[15:8];

  // Flags for addition: SREG layout {0,0,0,S,V,N,Z,C}
  function automatic logic [7:0] add_flags(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] res, input logic c);
    logic v, n, z;
    v = (a[7] & b[7] & ~res[7]) | (~a[7] & ~b[7] & res[7]);
    n = res[7];
    z = (res == 8'h00);
    return {3'b000, n ^ v, v, n, z, c};
  endfunction

  // Flags for subtraction/compare; zkeep lets SBC chain Z across bytes
  function automatic logic [7:0] sub_flags(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] res, input logic c,
                                           input logic zkeep);
    logic v, n, z;
    v = (a[7] & ~b[7] & ~res[7]) | (~a[7] & b[7] & res[7]);
    n = res[7];
    z = (res == 8'h00) & zkeep;
    return {3'b000, n ^ v, v, n, z, c};
  endfunction

  // Flags for bitwise logic: V cleared, C carried through unchanged
  function automatic logic [7:0] logic_flags(input logic [7:0] res, input logic c_old);
    logic n, z;
    n = res[7];
    z = (res == 8'h00);
    return {3'b000, n, 1'b0, n, z, c_old};
  endfunction

  assign op     = ROM_I;
  assign d5     = op[8:4];
  assign r5     = {op[9], op[3:0]};
  assign dh     = {1'b1, op[7:4]};
  assign kimm   = {op[11:8], op[3:0]};
  assign rd_v   = rf[d5];
  assign rr_v   = rf[r5];
  assign rdh_v  = rf[dh];
  assign br_off = {{7{op[9]}}, op[9:3]};
  assign rj_off = {{2{op[11]}}, op[11:0]};
  assign use_c  = (op[15:10] == 6'b000111) || (op[15:10] == 6'b000010);
  assign add9   = {1'b0, rd_v} + {1'b0, rr_v} + {8'h00, use_c & sreg[0]};
  assign sub9   = {1'b0, rd_v} - {1'b0, rr_v} - {8'h00, use_c & sreg[0]};
  assign subi9  = {1'b0, rdh_v} - {1'b0, kimm};
`ifdef AVR_MUL_EN
  assign prod   = {8'h00, rd_v} * {8'h00, rr_v};
`else
  assign prod   = 16'h0000;
`endif

  assign ROM_A = pc;

  // State register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = EXEC;
      EXEC:    state_nxt = go_mem ? MEM : FETCH;
      MEM:     state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // FSM output strobes
  always_comb begin
    exec_en = (state == EXEC);
    mem_en  = (state == MEM);
  end

  // Instruction decode and ALU: next PC, register write, next SREG
  always_comb begin
    pc_nxt   = pc + 14'd1;
    wr_en    = 1'b0;
    wr_addr  = d5;
    wr_data  = 8'h00;
    sreg_nxt = sreg;
    mul_en   = 1'b0;
    go_mem   = 1'b0;
    mem_ld   = 1'b0;
    case (op[15:10])
      6'b000011, 6'b000111: begin
        wr_en    = 1'b1;
        wr_data  = add9[7:0];
        sreg_nxt = add_flags(rd_v, rr_v, add9[7:0], add9[8]);
      end
      6'b000110: begin
        wr_en    = 1'b1;
        wr_data  = sub9[7:0];
        sreg_nxt = sub_flags(rd_v, rr_v, sub9[7:0], sub9[8], 1'b1);
      end
      6'b000010: begin
        wr_en    = 1'b1;
        wr_data  = sub9[7:0];
        sreg_nxt = sub_flags(rd_v, rr_v, sub9[7:0], sub9[8], sreg[1]);
      end
      6'b000101: sreg_nxt = sub_flags(rd_v, rr_v, sub9[7:0], sub9[8], 1'b1);
      6'b001000: begin
        wr_en    = 1'b1;
        wr_data  = rd_v & rr_v;
        sreg_nxt = logic_flags(rd_v & rr_v, sreg[0]);
      end
      6'b001001: begin
        wr_en    = 1'b1;
        wr_data  = rd_v ^ rr_v;
        sreg_nxt = logic_flags(rd_v ^ rr_v, sreg[0]);
      end
      6'b001010: begin
        wr_en    = 1'b1;
        wr_data  = rd_v | rr_v;
        sreg_nxt = logic_flags(rd_v | rr_v, sreg[0]);
      end
      6'b001011: begin
        wr_en   = 1'b1;
        wr_data = rr_v;
      end
      6'b111100: if (sreg[op[2:0]])  pc_nxt = pc + 14'd1 + $unsigned(br_off);
      6'b111101: if (!sreg[op[2:0]]) pc_nxt = pc + 14'd1 + $unsigned(br_off);
`ifdef AVR_MUL_EN
      6'b100111: begin
        mul_en   = 1'b1;
        sreg_nxt = {sreg[7:2], prod == 16'h0000, prod[15]};
      end
`endif
      6'b100100: begin
        if (op[3:0] == 4'b1100) begin
          go_mem = 1'b1;
          mem_ld = ~op[9];
        end
      end
      default: ;
    endcase
    case (op[15:12])
      4'b1110: begin
        wr_en   = 1'b1;
        wr_addr = dh;
        wr_data = kimm;
      end
      4'b0101: begin
        wr_en    = 1'b1;
        wr_addr  = dh;
        wr_data  = subi9[7:0];
        sreg_nxt = sub_flags(rdh_v, kimm, subi9[7:0], subi9[8], 1'b1);
      end
      4'b0011: sreg_nxt = sub_flags(rdh_v, kimm, subi9[7:0], subi9[8], 1'b1);
      4'b0111: begin
        wr_en    = 1'b1;
        wr_addr  = dh;
        wr_data  = rdh_v & kimm;
        sreg_nxt = logic_flags(rdh_v & kimm, sreg[0]);
      end
      4'b0110: begin
        wr_en    = 1'b1;
        wr_addr  = dh;
        wr_data  = rdh_v | kimm;
        sreg_nxt = logic_flags(rdh_v | kimm, sreg[0]);
      end
      4'b1100: pc_nxt = pc + 14'd1 + $unsigned(rj_off);
      default: ;
    endcase
  end

  // Architectural state: PC, register file, SREG and load capture
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      pc       <= RESET_PC;
      sreg     <= 8'h00;
      mem_ld_q <= 1'b0;
      mem_rd_q <= 5'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
    end else if (exec_en) begin
      pc       <= pc_nxt;
      sreg     <= sreg_nxt;
      mem_ld_q <= mem_ld;
      mem_rd_q <= d5;
      if (wr_en)  rf[wr_addr] <= wr_data;
      if (mul_en) begin
        rf[0] <= prod[7:0];
        rf[1] <= prod[15:8];
      end
    end else if (mem_en && mem_ld_q) begin
      rf[mem_rd_q] <= DAT_I[7:0];
    end
  end

  // Data bus: address/data launched at EXEC and held; store strobe lasts the MEM cycle
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ADR_O <= 22'h000000;
      DAT_O <= 16'h0000;
      WE_O  <= 1'b0;
    end else begin
      WE_O <= exec_en & go_mem & ~mem_ld;
      if (exec_en && go_mem) begin
        ADR_O <= {6'b000000, rf[27], rf[26]};
        if (!mem_ld) DAT_O <= {8'h00, rd_v};
      end
    end
  end

endmodule

// File: tb/tb_avr_core.sv
// tb_avr_core: directed program run against avr_core with a synchronous ROM model.
module tb_avr_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] rom_a;
  logic [15:0] rom_i;
  logic [21:0] adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        we;
  logic [15:0] rom [0:16383];
  int          checks = 0;
  int          errors = 0;

  avr_core #(.RESET_PC(14'h0000)) dut (
    .CLK_I(clk), .RST_I(rst_n), .ROM_A(rom_a), .ROM_I(rom_i),
    .ADR_O(adr), .DAT_I(dat_i), .DAT_O(dat_o), .WE_O(we)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM
  always @(posedge clk) rom_i <= rom[rom_a];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) rom[i] = 16'h0000;
    rom[0]  = 16'hE70F; // LDI R16,0x7F
    rom[1]  = 16'hE011; // LDI R17,0x01
    rom[2]  = 16'h0F01; // ADD R16,R17
    rom[3]  = 16'hE005; // LDI R16,0x05
    rom[4]  = 16'h3005; // CPI R16,0x05
    rom[5]  = 16'hF011; // BREQ +2
    rom[6]  = 16'hEE4E; // LDI R20,0xEE (skipped)
    rom[7]  = 16'hEE4E; // LDI R20,0xEE (skipped)
    rom[8]  = 16'hF411; // BRNE +2 (not taken)
    rom[9]  = 16'hE3A4; // LDI R26,0x34
    rom[10] = 16'hE1B2; // LDI R27,0x12
    rom[11] = 16'hEA25; // LDI R18,0xA5
    rom[12] = 16'h932C; // ST X,R18
    rom[13] = 16'h913C; // LD R19,X
    rom[14] = 16'h5001; // SUBI R16,0x01
    rom[15] = 16'h2E50; // MOV R5,R16
    rom[16] = 16'h2455; // EOR R5,R5
    rom[17] = 16'h5005; // SUBI R16,0x05
    rom[18] = 16'h700F; // ANDI R16,0x0F
    rom[19] = 16'hE180; // LDI R24,0x10
    rom[20] = 16'hE290; // LDI R25,0x20
    rom[21] = 16'h9F89; // MUL R24,R25
    rom[22] = 16'hFFFF; // unimplemented -> NOP
    rom[23] = 16'hCFFF; // RJMP -1

    rst_n = 1'b0;
    dat_i = 16'hFF3C;
    cyc(2);
    check("rst_rom_a", rom_a, 0);
    check("rst_we", we, 0);
    check("rst_adr", adr, 0);
    check("rst_dat_o", dat_o, 0);
    check("rst_sreg", dut.sreg, 0);

    @(negedge clk) rst_n = 1'b1;
    #1 check("first_fetch", rom_a, 0);
    cyc(2);
    check("ldi_midway_pc", rom_a, 0);
    cyc(1);
    check("ldi_3cyc_pc", rom_a, 1);
    cyc(6);
    check("add_pc", rom_a, 3);
    check("add_r16", dut.rf[16], 8'h80);
    check("add_r17", dut.rf[17], 8'h01);
    check("add_sreg", dut.sreg, 8'h0C);

    cyc(6);
    check("cpi_pc", rom_a, 5);
    check("cpi_sreg", dut.sreg, 8'h02);
    cyc(3);
    check("breq_taken_pc", rom_a, 8);
    cyc(3);
    check("brne_fall_pc", rom_a, 9);
    cyc(9);
    check("ldi_x_pc", rom_a, 12);
    check("skip_r20", dut.rf[20], 8'h00);

    cyc(2);
    check("st_exec_we", we, 0);
    cyc(1);
    check("st_mem_we", we, 1);
    check("st_adr", adr, 22'h001234);
    check("st_dat_o", dat_o, 16'h00A5);
    check("st_pc", rom_a, 13);
    cyc(1);
    check("st_we_drop", we, 0);
    check("st_adr_hold", adr, 22'h001234);

    cyc(3);
    check("ld_mem_we", we, 0);
    cyc(1);
    check("ld_r19", dut.rf[19], 8'h3C);
    check("ld_sreg", dut.sreg, 8'h02);
    check("ld_pc", rom_a, 14);
    check("ld_dat_o_hold", dat_o, 16'h00A5);
    cyc(2);
    check("after_ld_midway", rom_a, 14);
    cyc(1);
    check("subi_pc", rom_a, 15);
    check("subi_r16", dut.rf[16], 8'h04);
    check("subi_sreg", dut.sreg, 8'h00);

    cyc(3);
    check("mov_r5", dut.rf[5], 8'h04);
    cyc(3);
    check("eor_r5", dut.rf[5], 8'h00);
    check("eor_sreg", dut.sreg, 8'h02);
    cyc(3);
    check("subi_borrow_r16", dut.rf[16], 8'hFF);
    check("subi_borrow_sreg", dut.sreg, 8'h15);
    cyc(3);
    check("andi_r16", dut.rf[16], 8'h0F);
    check("andi_sreg", dut.sreg, 8'h01);

    cyc(9);
    check("mul_pc", rom_a, 22);
`ifdef AVR_MUL_EN
    check("mul_r0", dut.rf[0], 8'h00);
    check("mul_r1", dut.rf[1], 8'h02);
    check("mul_sreg", dut.sreg, 8'h00);
`else
    check("mul_nop_r0", dut.rf[0], 8'h00);
    check("mul_nop_r1", dut.rf[1], 8'h00);
    check("mul_nop_sreg", dut.sreg, 8'h01);
`endif
    cyc(3);
    check("nop_pc", rom_a, 23);
    cyc(3);
    check("rjmp_pc_a", rom_a, 23);
    cyc(3);
    check("rjmp_pc_b", rom_a, 23);
    check("rjmp_r24", dut.rf[24], 8'h10);

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rom_a", rom_a, 0);
    check("async_rst_we", we, 0);
    check("async_rst_adr", adr, 0);
    check("async_rst_r18", dut.rf[18], 8'h00);
    @(negedge clk) rst_n = 1'b1;
    cyc(3);
    check("rerun_pc", rom_a, 1);
    check("rerun_r16", dut.rf[16], 8'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
